// File: rtl/intbus_trace.sv
// Transaction trace buffer for one intbus port: captures write and read-data
// events with timestamps into a circular RAM, with address/type triggering.
module intbus_trace #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int TS_W   = 16,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int ENT_W  = TS_W + 2 + ADDR_W + DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] mon_addr,
  input  logic [DATA_W-1:0] mon_wdata,
  input  logic [DATA_W-1:0] mon_rdata,
  input  logic              mon_wr,
  input  logic              mon_rd,
  input  logic              mon_rvalid,
  input  logic              arm,
  input  logic              abort,
  input  logic [ADDR_W-1:0] trig_addr,
  input  logic [ADDR_W-1:0] trig_mask,
  input  logic [1:0]        trig_type,
  input  logic [PTR_W-1:0]  post_cnt,
  input  logic [PTR_W-1:0]  rd_idx,
  output logic [ENT_W-1:0]  rd_data,
  output logic [1:0]        state,
  output logic [PTR_W:0]    count,
  output logic [PTR_W-1:0]  trig_pos,
  output logic              dropped
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_POST  = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [TS_W-1:0]  TS_ONE   = 1;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wp_q, wp_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [PTR_W-1:0]   rem_q, rem_d;
  logic [PTR_W-1:0]   trig_wp_q, trig_wp_d;
  logic [PTR_W-1:0]   trig_pos_q, trig_pos_d;
  logic [TS_W-1:0]    ts_q, ts_d;
  logic [ADDR_W-1:0]  raddr_q, raddr_d;
  logic               dropped_q, dropped_d;
  logic               rd_vld_q, rd_vld_d;

  logic [ENT_W-1:0]   mem [DEPTH];
  logic [ENT_W-1:0]   mem_rdata_q;

  logic               wr_ev, rd_ev, capturing, store, hit;
  logic [1:0]         ev_type;
  logic [ADDR_W-1:0]  ev_addr;
  logic [DATA_W-1:0]  ev_data;
  logic [PTR_W-1:0]   wp_inc, oldest_next, trig_sel, rd_phys;
  logic [PTR_W:0]     count_inc;

  // A write always wins the single store slot over a coincident read-data beat.
  always_comb begin
    wr_ev     = mon_wr;
    rd_ev     = mon_rvalid & ~mon_wr;
    ev_type   = mon_wr ? 2'b01 : 2'b10;
    ev_addr   = mon_wr ? mon_addr : raddr_q;
    ev_data   = mon_wr ? mon_wdata : mon_rdata;
    capturing = (state_q == S_ARMED) || (state_q == S_POST);
    store     = capturing & (wr_ev | rd_ev) & ~arm & ~abort;
    hit       = ((wr_ev & trig_type[0]) | (rd_ev & trig_type[1])) &
                (((ev_addr ^ trig_addr) & trig_mask) == '0);
    wp_inc      = wp_q + PTR_ONE;
    count_inc   = (count_q == CNT_FULL) ? count_q : count_q + CNT_ONE;
    oldest_next = wp_inc - count_inc[PTR_W-1:0];
    trig_sel    = (state_q == S_ARMED) ? wp_q : trig_wp_q;
    rd_phys     = wp_q - count_q[PTR_W-1:0] + rd_idx;
  end

  always_comb begin
    state_d    = state_q;
    wp_d       = wp_q;
    count_d    = count_q;
    rem_d      = rem_q;
    trig_wp_d  = trig_wp_q;
    trig_pos_d = trig_pos_q;
    ts_d       = ts_q;
    dropped_d  = dropped_q;
    raddr_d    = mon_rd ? mon_addr : raddr_q;
    rd_vld_d   = ({1'b0, rd_idx} < count_q);
    if (abort) begin
      state_d = S_IDLE;
      count_d = '0;
    end else if (arm) begin
      state_d   = S_ARMED;
      count_d   = '0;
      wp_d      = '0;
      ts_d      = '0;
      dropped_d = 1'b0;
    end else begin
      if (capturing) ts_d = ts_q + TS_ONE;
      if (store) begin
        wp_d    = wp_inc;
        count_d = count_inc;
        if (mon_wr && mon_rvalid) dropped_d = 1'b1;
        // trig_pos is the trigger's distance from the oldest entry after this store
        if (state_q == S_ARMED && hit) begin
          if (post_cnt == '0) begin
            state_d    = S_DONE;
            trig_pos_d = trig_sel - oldest_next;
          end else begin
            state_d   = S_POST;
            rem_d     = post_cnt;
            trig_wp_d = wp_q;
          end
        end else if (state_q == S_POST) begin
          if (rem_q == PTR_ONE) begin
            state_d    = S_DONE;
            trig_pos_d = trig_sel - oldest_next;
          end else begin
            rem_d = rem_q - PTR_ONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      wp_q       <= '0;
      count_q    <= '0;
      rem_q      <= '0;
      trig_wp_q  <= '0;
      trig_pos_q <= '0;
      ts_q       <= '0;
      raddr_q    <= '0;
      dropped_q  <= 1'b0;
      rd_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
      trig_wp_q  <= trig_wp_d;
      trig_pos_q <= trig_pos_d;
      ts_q       <= ts_d;
      raddr_q    <= raddr_d;
      dropped_q  <= dropped_d;
      rd_vld_q   <= rd_vld_d;
    end
  end

  // Plain synchronous RAM with no reset so it maps onto block memory.
  always_ff @(posedge clk) begin
    if (store) mem[wp_q] <= {ts_q, ev_type, ev_addr, ev_data};
    mem_rdata_q <= mem[rd_phys];
  end

  assign rd_data  = rd_vld_q ? mem_rdata_q : '0;
  assign state    = state_q;
  assign count    = count_q;
  assign trig_pos = trig_pos_q;
  assign dropped  = dropped_q;

endmodule

// File: doc/intbus_trace.md
# intbus_trace

Parametrised transaction trace buffer for the internal register bus; successor to the bus-debug probe wrapper. It passively monitors one intbus port and stores write and read-data transactions with timestamps in a circular on-chip buffer. It supports address/mask/type triggering, a programmable post-trigger depth and in-fabric readout, so captures need no vendor ILA. It sits beside any intbus slave or master, and its control and readout ports are mapped into a register block by the integrator.

## Interface
- ADDR_W, 16: monitored address width.
- DATA_W, 32: monitored data width.
- DEPTH, 256: buffer entries; power of two, at least 4.
- TS_W, 16: timestamp width.
- PTR_W, $clog2(DEPTH): derived; not overridden.
- ENT_W, TS_W+2+ADDR_W+DATA_W: derived entry width.

- clk  in  1  bus clock; the only clock.
- resetn  in  1  asynchronous, active-low reset.
- mon_addr  in  ADDR_W  monitored bus address.
- mon_wdata  in  DATA_W  monitored write data.
- mon_rdata  in  DATA_W  monitored read data.
- mon_wr  in  1  write strobe; one cycle per write.
- mon_rd  in  1  read request strobe.
- mon_rvalid  in  1  read data valid.
- arm  in  1  pulse: clear buffer and start capture.
- abort  in  1  pulse: return to IDLE.
- trig_addr  in  ADDR_W  trigger address.
- trig_mask  in  ADDR_W  1 = compare this bit.
- trig_type  in  2  01 = write, 10 = read data, 11 = either, 00 = trigger disabled.
- post_cnt  in  PTR_W  entries stored after the trigger entry.
- rd_idx  in  PTR_W  logical readout index; 0 = oldest entry.
- rd_data  out  ENT_W  entry {ts, type, addr, data}; registered.
- state  out  2  00 IDLE, 01 ARMED, 10 POST, 11 DONE.
- count  out  PTR_W+1  valid entries, saturating at DEPTH.
- trig_pos  out  PTR_W  logical index of the trigger entry; valid in DONE.
- dropped  out  1  sticky flag: a rvalid was lost to a simultaneous wr.

## Operation
- Reset: state=IDLE, count=0, trig_pos=0, dropped=0, rd_data=0, write pointer=0, timestamp=0, read-address latch=0.
- Events:
  - A write event is mon_wr=1. It stores type=01, addr=mon_addr, data=mon_wdata.
  - A read event is mon_rvalid=1. It stores type=10, addr=the address latched on the most recent mon_rd, data=mon_rdata.
- Simultaneous mon_wr and mon_rvalid: the write is stored and the read is discarded; dropped is set.
- If mon_rd and mon_rvalid occur in the same cycle, the read event uses the address latched before that cycle.
- Storage:
  - Events are stored only in ARMED or POST, one entry per cycle at the write pointer.
  - After each store, the pointer increments modulo DEPTH and count increments until it saturates at DEPTH.
  - When full, the oldest entry is overwritten.
- Timestamp: cleared on arm, increments every cycle in ARMED and POST, wraps modulo 2^TS_W. Each entry captures the timestamp value of its store cycle.
- Trigger condition: an event whose type is enabled by trig_type and where ((mon_addr or latched read address) XOR trig_addr) AND trig_mask == 0.
- FSM:
  - IDLE --arm--> ARMED. arm clears count, pointer, timestamp and dropped.
  - ARMED --trigger event--> POST. The trigger entry is stored, and trig_pos is recorded as its logical index once capture ends. If post_cnt=0, the transition goes directly to DONE.
  - POST: each stored event decrements the remaining count, which is loaded from post_cnt. After the post_cnt-th event, go to DONE.
  - DONE: no stores. Holds until arm (re-arm, same as from IDLE) or abort.
  - abort in any state goes to IDLE and clears count. abort wins over a simultaneous arm.
  - arm in ARMED or POST restarts capture.
- Readout:
  - physical = (write pointer - count + rd_idx) mod DEPTH.
  - rd_idx >= count returns 0.
  - Readout is allowed in any state. Entries are coherent only in DONE or IDLE.
- Buffer is a single-write, single-read synchronous RAM (inferred BRAM).

## Timing
- An event at cycle N is visible via rd_data from cycle N+2: stored at N, then a 1-cycle registered read.
- rd_data latency is 1 cycle from rd_idx.
- state changes to POST or DONE at the clock edge that stores the triggering or final entry.
- count, trig_pos and dropped update on the same edge as the store.
- arm and abort take effect at the next edge. An event in the arm cycle is not stored.
- Asynchronous reset mid-capture: all outputs return immediately to their reset values, and buffer contents are undefined.

## Test plan
- Arm, then 5 writes to 0x0010..0x0014 with no trigger (trig_type=00) -> state=ARMED, count=5; rd_idx=0 gives addr=0x0010, type=01.
- trig_addr=0x0040, mask=0xFFFF, type=01, post_cnt=3; writes to 0x003E..0x0045 -> DONE after the write to 0x0043; count=6, trig_pos=2.
- Read to 0x0020, rvalid 2 cycles later with data 0xDEADBEEF, trig_type=10 on 0x0020, post_cnt=0 -> DONE; entry type=10, addr=0x0020, data=0xDEADBEEF.
- DEPTH=256, no trigger, 300 writes with data=i -> count=256; rd_idx=0 gives data=44, rd_idx=255 gives data=299.
- mon_wr and mon_rvalid in the same cycle -> only the write is stored; dropped=1 until the next arm.
- abort during POST -> state=IDLE, count=0. Reset asserted during ARMED -> all outputs return to their reset values.
